fm_sb_readout: RTL
==================

# fm_sb_readout

Streaming read-out engine for one fm spy buffer: on command it freezes the buffer, walks its AXI-side spy memory port from a start address for a programmed number of words, and emits the words on a valid/ready stream. It sits on the read port of a SpyBuffer instance, where the AXI register interface would otherwise be, and feeds a downstream link or DMA packer. Words are delivered in address order with wrap-around, and no word is lost or duplicated under back-pressure.

## Interface
- DW, 32: spy word width, equal to axi_dw; must be >= 32 when FM_SB_READOUT_HDR_EN is defined.
- AW, 10: spy memory address width, equal to axi_sb_addr_width of the target buffer.
- FREEZE_WAIT, 4: cycles between asserting freeze and the first spy read (1..15).

- clk_hs  in  1  sole clock.
- rst_hs  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe, accepted in IDLE only.
- start_addr  in  AW  first spy address, sampled with start.
- length  in  AW+1  word count, sampled with start; 0 means no data words; values above 2^AW are clamped to 2^AW.
- abort  in  1  synchronous abort of an active read-out.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a read-out completes normally.
- freeze  out  1  drives the SpyBuffer freeze input.
- spy_en  out  1  spy read strobe.
- spy_addr  out  AW  spy read address.
- spy_data  in  DW  spy read data, valid exactly 1 cycle after spy_en.
- out_data  out  DW  stream data.
- out_vld  out  1  stream valid.
- out_rdy  in  1  stream ready; a transfer occurs when out_vld and out_rdy are both high at a rising edge.

## Operation
- States:
  - IDLE: waits for start.
  - FRZ: counts down FREEZE_WAIT cycles.
  - RD: issues spy reads.
  - DRAIN: no reads remaining; waits until the buffer empties.
  - FIN: one cycle; done is high.
- IDLE -> FRZ on start. FRZ -> RD when the counter expires.
- RD -> DRAIN after the last read is issued. RD goes directly to DRAIN when length is 0.
- DRAIN -> FIN when the buffer is empty and no read is in flight. FIN -> IDLE.
- abort in any non-IDLE state:
  - next state is IDLE; the buffer and any in-flight read are discarded.
  - done does not pulse; freeze drops on the following cycle.
- start while busy is ignored. start and abort together in IDLE: start wins.
- freeze is high in FRZ, RD, DRAIN and FIN.
- Address generation:
  - spy_addr begins at start_addr and increments by 1 per issued read, modulo 2^AW (wraps from 2^AW-1 to 0).
  - A remaining-read counter of AW+1 bits decrements per issue.
- Output buffering:
  - A 2-entry skid FIFO holds read data.
  - spy_en is issued in RD only when (occupancy + in-flight − pop this cycle) <= 1, so the FIFO never overflows.
  - out_data and out_vld come directly from the FIFO head register.
- Stream rules:
  - out_data is held stable while out_vld is high and out_rdy is low.
  - out_vld never drops without a transfer, except on abort or reset.

## Timing
- Reset values: state IDLE; busy, done, freeze, spy_en, out_vld all 0; spy_addr, out_data 0; FIFO empty.
- Cycle numbering: start is sampled high in cycle 0, and W = FREEZE_WAIT.
  - busy and freeze go high in cycle 1.
  - The first spy_en occurs in cycle W+1; its data is captured at the end of cycle W+2.
  - The first data out_vld occurs in cycle W+3.
- With out_rdy held high, throughput is 1 word per cycle.
- With length N and no stalls, the last transfer is in cycle W+N+2, done is high in cycle W+N+3, and busy and freeze fall in cycle W+N+4.
- Back-pressure:
  - A stall of k cycles delays all later events by k.
  - Reads resume in the cycle out_rdy returns.
- reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous).

## Configuration
- FM_SB_READOUT_HDR_EN defined:
  - A header word is pushed into the FIFO on the FRZ->RD transition.
  - Header value: {16'hFA5E, length[15:0]}, zero-extended to DW.
  - The header appears on out_vld in cycle W+1 and counts against FIFO occupancy.
  - Data timing follows header back-pressure; with length 0, only the header is sent.
- FM_SB_READOUT_HDR_EN undefined: no header; the stream carries data words only, and length 0 produces no transfers.

## Structure
- Shared package fm_sb_pkg holds:
  - the state enum fm_sb_ro_state_t;
  - the constant FM_SB_RO_HDR_TAG = 16'hFA5E.
- Sub-module fm_sb_ro_skid: a 2-entry valid/ready FIFO with occupancy output.
- The FSM, counters and address generator live in fm_sb_readout.

## Test plan
- start_addr=0x010, length=4, out_rdy=1 -> spy_addr 0x010..0x013; out_data equals the memory words at those addresses; done in cycle W+7.
- start_addr=0x3FE, length=4, AW=10 -> read addresses 0x3FE, 0x3FF, 0x000, 0x001; 4 transfers.
- length=8, out_rdy toggling 1/0 each cycle -> exactly 8 transfers, in order, no duplicates; out_data stable during stalls; spy_en never leaves more than 2 words pending.
- abort in cycle W+3 of a length=16 run -> no done pulse; out_vld=0 and busy=0 on the next cycle; a new start then reads correctly.
- length=0 -> no data transfers; with FM_SB_READOUT_HDR_EN defined, exactly one transfer 0xFA5E0000, then done.
- rst_hs pulsed mid-RD -> all outputs 0 immediately; a second start during busy is ignored.

Source files
------------

// File: rtl/fm_sb_pkg.sv
// Shared types for the fm spy-buffer read-out engine.
// State encoding and the stream header tag.
package fm_sb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRZ,
        S_RD,
        S_DRAIN,
        S_FIN
    } fm_sb_ro_state_t;

    localparam logic [15:0] FM_SB_RO_HDR_TAG = 16'hFA5E;

endpackage

// File: rtl/fm_sb_readout_if.sv
// Spy-memory read port plus outgoing valid/ready stream.
// master = read-out engine, slave = spy memory / stream sink.
interface fm_sb_readout_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          spy_en;
    logic [AW-1:0] spy_addr;
    logic [DW-1:0] spy_data;
    logic [DW-1:0] out_data;
    logic          out_vld;
    logic          out_rdy;

    modport master (
        output spy_en, spy_addr, out_data, out_vld,
        input  spy_data, out_rdy
    );

    modport slave (
        input  spy_en, spy_addr, out_data, out_vld,
        output spy_data, out_rdy
    );
endinterface

// File: rtl/fm_sb_ro_skid.sv
// Two-entry skid FIFO; the head register drives the stream directly.
// pop must already be qualified with vld.
module fm_sb_ro_skid #(
    parameter int DW = 32
) (
    input  logic          clk_hs,
    input  logic          rst_hs,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          vld,
    output logic [1:0]    occ
);
    logic [DW-1:0] tail_q;

    always_ff @(posedge clk_hs or posedge rst_hs) begin
        if (rst_hs) begin
            head   <= '0;
            tail_q <= '0;
            occ    <= 2'd0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= din;
                    else             tail_q <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail_q;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        head   <= tail_q;
                        tail_q <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign vld = (occ != 2'd0);
endmodule

// File: rtl/fm_sb_readout.sv
// fm spy-buffer read-out engine: freeze, walk spy memory, stream words.
// Optional stream header word: define FM_SB_READOUT_HDR_EN.
module fm_sb_readout #(
    parameter int DW          = 32,
    parameter int AW          = 10,
    parameter int FREEZE_WAIT = 4
) (
    input  logic          clk_hs,
    input  logic          rst_hs,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   length,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          freeze,
    fm_sb_readout_if.master bus
);
    import fm_sb_pkg::*;

    localparam logic [3:0]  WAIT_LD = 4'(FREEZE_WAIT - 1);
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    fm_sb_ro_state_t state_q;
    logic [3:0]      wait_q;
    logic [AW:0]     rem_q;
    logic [AW-1:0]   addr_q;
    logic            infl_q;

    logic [AW:0]   len_cl;
    logic [1:0]    occ;
    logic [2:0]    pend;
    logic          pop;
    logic          issue;
    logic          drained;
    logic          flush;
    logic          skid_push;
    logic [DW-1:0] skid_din;

    assign len_cl = (length > MAX_LEN) ? MAX_LEN : length;
    assign pop    = bus.out_vld & bus.out_rdy;
    assign flush  = abort & busy;

    // Words that will still be held after this cycle's pop.
    assign pend = 3'(occ) + 3'(infl_q) - 3'(pop);

    assign issue = (state_q == S_RD) && (rem_q != '0)
                && (pend <= 3'd1) && !abort;

    assign drained = !infl_q
                  && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    assign busy         = (state_q != S_IDLE);
    assign freeze       = busy;
    assign done         = (state_q == S_FIN);
    assign bus.spy_en   = issue;
    assign bus.spy_addr = addr_q;

`ifdef FM_SB_READOUT_HDR_EN
    logic [AW:0] len_q;
    logic        hdr_push;

    assign hdr_push  = (state_q == S_FRZ) && (wait_q == 4'd0) && !abort;
    assign skid_push = infl_q | hdr_push;
    assign skid_din  = infl_q ? bus.spy_data
                     : DW'({FM_SB_RO_HDR_TAG, 16'(len_q)});

    always_ff @(posedge clk_hs or posedge rst_hs) begin
        if (rst_hs)
            len_q <= '0;
        else if ((state_q == S_IDLE) && start)
            len_q <= length;
    end
`else
    assign skid_push = infl_q;
    assign skid_din  = bus.spy_data;
`endif

    always_ff @(posedge clk_hs or posedge rst_hs) begin
        if (rst_hs) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
            rem_q   <= '0;
            addr_q  <= '0;
            infl_q  <= 1'b0;
        end else begin
            infl_q <= issue;
            if (issue) begin
                addr_q <= addr_q + AW'(1);
                rem_q  <= rem_q - (AW+1)'(1);
            end
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: if (start) begin
                        state_q <= S_FRZ;
                        wait_q  <= WAIT_LD;
                        addr_q  <= start_addr;
                        rem_q   <= len_cl;
                    end
                    S_FRZ: begin
                        if (wait_q == 4'd0) state_q <= S_RD;
                        else                wait_q  <= wait_q - 4'd1;
                    end
                    S_RD: begin
                        if ((rem_q == '0)
                            || (issue && (rem_q == (AW+1)'(1))))
                            state_q <= S_DRAIN;
                    end
                    S_DRAIN: if (drained) state_q <= S_FIN;
                    S_FIN:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    fm_sb_ro_skid #(.DW(DW)) u_skid (
        .clk_hs (clk_hs),
        .rst_hs (rst_hs),
        .flush  (flush),
        .push   (skid_push),
        .din    (skid_din),
        .pop    (pop),
        .head   (bus.out_data),
        .vld    (bus.out_vld),
        .occ    (occ)
    );
endmodule
